// File: rtl/isr_sequencer.sv
// isr_sequencer: interrupt entry/exit sequencer for a small CPU core.
// On entry it pushes the return PC (low byte, then high byte) onto a stack RAM
// and loads the vector. On RETI it pops the PC back and clears the in-service
// flag. The stack pointer is an 8-bit register that wraps modulo 256.
// Optional build macro: ISR_NEST_EN allows INT0 to preempt an INT1 handler,
// giving two-level nesting. Without it, any in-service flag blocks all requests.
//
// state   | meaning
// IDLE    | waiting for an instruction boundary request or a RETI
// PUSH_L  | write pc_ret[7:0] at SP+1
// PUSH_H  | write pc_ret[15:8] at SP+1
// VECTOR  | load the vector PC, acknowledge, set in-service flag
// POP_H   | read the high return byte at SP
// POP_L   | capture the high byte, read the low return byte at SP
// RESTORE | load the return PC, clear the highest-priority in-service flag
module isr_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  irq_req,
  input  logic        instr_done,
  input  logic        reti,
  input  logic [15:0] pc_in,
  input  logic [7:0]  stk_dout,
  output logic        stk_we,
  output logic        stk_re,
  output logic [7:0]  stk_addr,
  output logic [7:0]  stk_din,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic [1:0]  int_ack,
  output logic [1:0]  in_service,
  output logic        cpu_hold
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PUSH_L  = 3'd1;
  localparam logic [2:0] S_PUSH_H  = 3'd2;
  localparam logic [2:0] S_VECTOR  = 3'd3;
  localparam logic [2:0] S_POP_H   = 3'd4;
  localparam logic [2:0] S_POP_L   = 3'd5;
  localparam logic [2:0] S_RESTORE = 3'd6;

  localparam logic [1:0]  SRC_INT0 = 2'b10;
  localparam logic [1:0]  SRC_INT1 = 2'b01;
  localparam logic [15:0] VEC_INT0 = 16'h0003;
  localparam logic [15:0] VEC_INT1 = 16'h0013;

  logic [2:0]  state;
  logic [2:0]  state_nxt;
  logic [7:0]  sp;
  logic [15:0] pc_ret;
  logic [7:0]  ret_hi;
  logic [1:0]  src;

  logic elig0;
  logic elig1;
  logic take0;
  logic take1;
  logic go_push;
  logic go_pop;

`ifdef ISR_NEST_EN
  // INT0 may preempt a running INT1 handler
  assign elig0 = (in_service == 2'b00) || (in_service == 2'b01);
`else
  assign elig0 = (in_service == 2'b00);
`endif
  assign elig1 = (in_service == 2'b00);

  // INT0 wins when both lines are raised
  assign take0   = irq_req[1] & elig0;
  assign take1   = irq_req[0] & elig1 & ~take0;
  assign go_pop  = reti & (in_service != 2'b00);
  // reti blocks entry even when it is itself ignored
  assign go_push = instr_done & ~reti & (take0 | take1);

  // Next-state selection; inputs are only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (go_pop)       state_nxt = S_POP_H;
        else if (go_push) state_nxt = S_PUSH_L;
      end
      S_PUSH_L:  state_nxt = S_PUSH_H;
      S_PUSH_H:  state_nxt = S_VECTOR;
      S_VECTOR:  state_nxt = S_IDLE;
      S_POP_H:   state_nxt = S_POP_L;
      S_POP_L:   state_nxt = S_RESTORE;
      S_RESTORE: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Output decode from the current state only, so reset forces everything low
  always_comb begin
    stk_we   = 1'b0;
    stk_re   = 1'b0;
    stk_addr = 8'h00;
    stk_din  = 8'h00;
    pc_load  = 1'b0;
    pc_next  = 16'h0000;
    int_ack  = 2'b00;
    case (state)
      S_PUSH_L: begin
        stk_we   = 1'b1;
        stk_addr = sp + 8'd1;
        stk_din  = pc_ret[7:0];
      end
      S_PUSH_H: begin
        stk_we   = 1'b1;
        stk_addr = sp + 8'd1;
        stk_din  = pc_ret[15:8];
      end
      S_VECTOR: begin
        pc_load = 1'b1;
        int_ack = src;
        pc_next = src[1] ? VEC_INT0 : VEC_INT1;
      end
      S_POP_H: begin
        stk_re   = 1'b1;
        stk_addr = sp;
      end
      S_POP_L: begin
        stk_re   = 1'b1;
        stk_addr = sp;
      end
      S_RESTORE: begin
        pc_load = 1'b1;
        pc_next = {ret_hi, stk_dout};
      end
      default: ;
    endcase
  end

  assign cpu_hold = (state != S_IDLE);

  // State, stack pointer, latched source/return address and in-service flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      sp         <= 8'h07;
      in_service <= 2'b00;
      pc_ret     <= 16'h0000;
      ret_hi     <= 8'h00;
      src        <= 2'b00;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (!go_pop && go_push) begin
            src    <= take0 ? SRC_INT0 : SRC_INT1;
            pc_ret <= pc_in;
          end
        end
        S_PUSH_L: sp <= sp + 8'd1;
        S_PUSH_H: sp <= sp + 8'd1;
        S_VECTOR: in_service <= in_service | src;
        S_POP_H:  sp <= sp - 8'd1;
        S_POP_L: begin
          ret_hi <= stk_dout;
          sp     <= sp - 8'd1;
        end
        S_RESTORE: begin
          if (in_service[1]) in_service[1] <= 1'b0;
          else               in_service[0] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_isr_sequencer.sv
// Testbench for isr_sequencer: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural model of in-service flags
// and a return-address stack. Honors ISR_NEST_EN when defined.
module tb_isr_sequencer;

`ifdef ISR_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  irq_req = 2'b00;
  logic        instr_done = 1'b0;
  logic        reti = 1'b0;
  logic [15:0] pc_in = 16'h0000;
  logic [7:0]  stk_dout = 8'h00;
  logic        stk_we, stk_re, pc_load, cpu_hold;
  logic [7:0]  stk_addr, stk_din;
  logic [15:0] pc_next;
  logic [1:0]  int_ack, in_service;

  isr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .irq_req(irq_req), .instr_done(instr_done),
    .reti(reti), .pc_in(pc_in), .stk_dout(stk_dout), .stk_we(stk_we),
    .stk_re(stk_re), .stk_addr(stk_addr), .stk_din(stk_din),
    .pc_load(pc_load), .pc_next(pc_next), .int_ack(int_ack),
    .in_service(in_service), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] pc;
    logic [1:0]  ack;
    logic [1:0]  is;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] m_stack[$];
  logic [1:0]  m_is = 2'b00;
  int          busy = 0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [7:0]  mem [0:255];
  logic [7:0]  we_log[$];
  logic [7:0]  re_log[$];

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  // stack RAM with one-cycle read latency, plus access logs
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (stk_we) begin
      mem[stk_addr] <= stk_din;
      we_log.push_back(stk_addr);
    end
    if (stk_re) begin
      stk_dout <= mem[stk_addr];
      re_log.push_back(stk_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  // reference model: acts on one IDLE-cycle input set
  task automatic model_eval(input logic [1:0] irq, input logic done, input logic rt,
                            input logic [15:0] pc);
    exp_t       e;
    logic       e0, e1;
    logic [1:0] s;
    e0 = NEST ? (m_is[1] == 1'b0) : (m_is == 2'b00);
    e1 = (m_is == 2'b00);
    if (rt) begin
      if (m_is != 2'b00) begin
        e.pc = m_stack.pop_back();
        if (m_is[1]) m_is[1] = 1'b0;
        else         m_is[0] = 1'b0;
        e.cyc = cyc + 3;
        e.ack = 2'b00;
        e.is  = m_is;
        exp_q.push_back(e);
        busy = 3;
      end
    end else if (done) begin
      s = (irq[1] && e0) ? 2'b10 : ((irq[0] && e1) ? 2'b01 : 2'b00);
      if (s != 2'b00) begin
        m_stack.push_back(pc);
        m_is  = m_is | s;
        e.cyc = cyc + 3;
        e.pc  = s[1] ? 16'h0003 : 16'h0013;
        e.ack = s;
        e.is  = m_is;
        exp_q.push_back(e);
        busy = 3;
      end
    end
  endtask

  // one clock of stimulus, driven at the falling edge
  task automatic step(input logic [1:0] irq, input logic done, input logic rt,
                      input logic [15:0] pc);
    @(negedge clk);
    check("cpu_hold", {31'b0, cpu_hold}, {31'b0, busy != 0});
    if (busy != 0) busy--;
    else model_eval(irq, done, rt, pc);
    irq_req = irq; instr_done = done; reti = rt; pc_in = pc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b00, 1'b0, 1'b0, 16'h0000);
  endtask

  // asserts reset at the current time, checks reset values, releases at next negedge
  task automatic do_reset();
    rst_n = 1'b0;
    irq_req = 2'b00; instr_done = 1'b0; reti = 1'b0; pc_in = 16'h0000;
    #1;
    check("rst_sp", {24'b0, dut.sp}, 32'h07);
    check("rst_in_service", {30'b0, in_service}, 32'h0);
    check("rst_pc_load", {31'b0, pc_load}, 32'h0);
    check("rst_stk_we", {31'b0, stk_we}, 32'h0);
    check("rst_cpu_hold", {31'b0, cpu_hold}, 32'h0);
    exp_q.delete(); m_stack.delete(); m_is = 2'b00; busy = 0;
    @(negedge clk);
    rst_n = 1'b1;
    we_log.delete(); re_log.delete();
  endtask

  // scoreboard monitor
  logic       is_pending = 1'b0;
  logic [1:0] is_exp = 2'b00;
  always @(negedge clk) begin
    exp_t e;
    if (is_pending) begin
      check("in_service_after_load", {30'b0, in_service}, {30'b0, is_exp});
      is_pending = 1'b0;
    end
    if (pc_load) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pc_load: actual pc_next %0h required no load", pc_next);
      end else begin
        e = exp_q.pop_front();
        check("pc_load_cycle", cyc, e.cyc);
        check("pc_next", {16'b0, pc_next}, {16'b0, e.pc});
        check("int_ack", {30'b0, int_ack}, {30'b0, e.ack});
        is_exp = e.is;
        is_pending = 1'b1;
      end
    end else begin
      check("int_ack_idle", {30'b0, int_ack}, 32'h0);
    end
  end

  initial begin
    logic [1:0]  r_irq;
    logic        r_done, r_rt;
    logic [15:0] r_pc;
    repeat (2) @(negedge clk);
    do_reset();

    // INT0 entry from reset
    step(2'b10, 1'b1, 1'b0, 16'h1234);
    idle(4);
    check("push_lo_byte", {24'b0, mem[8]}, 32'h34);
    check("push_hi_byte", {24'b0, mem[9]}, 32'h12);
    check("sp_after_entry", {24'b0, dut.sp}, 32'h09);
    check("in_service_int0", {30'b0, in_service}, 32'h2);

    // RETI back to 1234
    re_log.delete();
    step(2'b00, 1'b0, 1'b1, 16'h0000);
    idle(4);
    check("pop_count", re_log.size(), 2);
    if (re_log.size() == 2) begin
      check("pop_addr0", {24'b0, re_log[0]}, 32'h09);
      check("pop_addr1", {24'b0, re_log[1]}, 32'h08);
    end
    check("sp_after_reti", {24'b0, dut.sp}, 32'h07);
    check("in_service_cleared", {30'b0, in_service}, 32'h0);

    // simultaneous requests pick INT0; INT1 held off while in service
    step(2'b11, 1'b1, 1'b0, 16'h4000);
    for (int i = 0; i < 8; i++) step(2'b01, 1'b1, 1'b0, 16'h4100);
    check("int1_blocked", {30'b0, in_service}, 32'h2);
    step(2'b01, 1'b1, 1'b1, 16'h4100);   // reti wins over the request
    idle(4);
    step(2'b01, 1'b1, 1'b0, 16'h5000);
    idle(4);
    step(2'b00, 1'b0, 1'b1, 16'h0000);
    idle(4);

    // INT0 arriving during INT1 handler
    step(2'b01, 1'b1, 1'b0, 16'h2000);
    idle(4);
    step(2'b10, 1'b1, 1'b0, 16'h2100);
    idle(4);
    check("nest_in_service", {30'b0, in_service}, NEST ? 32'h3 : 32'h1);
    check("nest_sp", {24'b0, dut.sp}, NEST ? 32'h0B : 32'h09);
    step(2'b00, 1'b0, 1'b1, 16'h0000);
    idle(4);
    check("nest_first_reti_is", {30'b0, in_service}, NEST ? 32'h1 : 32'h0);
    step(2'b00, 1'b0, 1'b1, 16'h0000);
    idle(4);
    check("nest_final_sp", {24'b0, dut.sp}, 32'h07);

    // reset in the middle of a push
    step(2'b10, 1'b1, 1'b0, 16'h7777);
    idle(2);
    check("in_push_h", {31'b0, stk_we}, 32'h1);
    do_reset();
    idle(5);
    check("no_write_after_reset", we_log.size(), 0);
    check("sp_after_abort", {24'b0, dut.sp}, 32'h07);

    // stack pointer wrap
    force dut.sp = 8'hFF;
    idle(1);
    release dut.sp;
    we_log.delete();
    step(2'b01, 1'b1, 1'b0, 16'hABCD);
    idle(4);
    check("wrap_write_count", we_log.size(), 2);
    if (we_log.size() == 2) begin
      check("wrap_addr0", {24'b0, we_log[0]}, 32'h00);
      check("wrap_addr1", {24'b0, we_log[1]}, 32'h01);
    end
    check("wrap_lo", {24'b0, mem[0]}, 32'hCD);
    check("wrap_hi", {24'b0, mem[1]}, 32'hAB);
    check("wrap_sp", {24'b0, dut.sp}, 32'h01);
    step(2'b00, 1'b0, 1'b1, 16'h0000);
    idle(4);
    check("wrap_sp_back", {24'b0, dut.sp}, 32'hFF);

    // randomized traffic, including inputs that must be ignored while busy
    @(negedge clk);
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      r_irq  = 2'($urandom_range(0, 3));
      r_done = 1'($urandom_range(0, 1));
      r_rt   = ($urandom_range(0, 3) == 0);
      r_pc   = 16'($urandom);
      step(r_irq, r_done, r_rt, r_pc);
    end
    idle(6);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/isr_sequencer.md
ISR_SEQUENCER -- requirements
Module: isr_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, using the port names below.
REQ-002 SHALL have port: clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port: irq_req  in  2  request from the interrupt controller: 2'b10 = INT0, 2'b01 = INT1, 2'b00 = none.
REQ-005 SHALL have port: instr_done  in  1  CPU instruction-boundary strobe; requests are accepted only on this cycle.
REQ-006 SHALL have port: reti  in  1  one-cycle strobe when the CPU executes RETI.
REQ-007 SHALL have port: pc_in  in  16  PC of the next instruction (return address).
REQ-008 SHALL have port: stk_dout  in  8  stack RAM read data, valid one cycle after stk_re.
REQ-009 SHALL have ports out: stk_we 1, stk_re 1, stk_addr 8, stk_din 8 (stack RAM control).
REQ-010 SHALL have ports out: pc_load 1 and pc_next 16, a one-cycle PC overwrite to the CPU.
REQ-011 SHALL have port: int_ack  out  2  one-cycle acknowledge to the controller, same encoding as irq_req.
REQ-012 SHALL have port: in_service  out  2  {INT0, INT1} in-service flags.
REQ-013 SHALL have port: cpu_hold  out  1  stalls the CPU; high in every state except IDLE.

Function
REQ-014 FSM states SHALL be: IDLE, PUSH_L, PUSH_H, VECTOR, POP_H, POP_L, RESTORE.
REQ-015 Eligibility: INT0 SHALL be eligible when in_service == 2'b00; INT1 SHALL be eligible when in_service == 2'b00; irq_req == 2'b11 SHALL select INT0.
REQ-016 IDLE SHALL go to PUSH_L when instr_done = 1, reti = 0, and a request is eligible. On this transition it SHALL latch the source and capture pc_in into pc_ret.
REQ-017 PUSH_L SHALL drive stk_we = 1, stk_addr = SP+1 and stk_din = pc_ret[7:0], and SHALL update SP to SP+1.
REQ-018 PUSH_H SHALL drive stk_we = 1, stk_addr = SP+1 and stk_din = pc_ret[15:8], and SHALL update SP to SP+1.
REQ-019 VECTOR SHALL drive pc_load = 1, set int_ack to the latched source, set that source's in_service bit, and return to IDLE. pc_next SHALL be 16'h0003 for INT0 and 16'h0013 for INT1.
REQ-020 Request latency: instr_done at cycle N SHALL give pc_load at cycle N+3.
REQ-021 IDLE SHALL go to POP_H on reti = 1 when in_service != 0. reti with in_service == 0 SHALL be ignored.
REQ-022 reti and an eligible request in the same cycle: reti SHALL win; the request is re-evaluated at the next instr_done.
REQ-023 POP_H SHALL drive stk_re = 1 and stk_addr = SP, and SHALL update SP to SP-1.
REQ-024 POP_L SHALL capture stk_dout into ret_hi, drive stk_re = 1 and stk_addr = SP, and update SP to SP-1.
REQ-025 RESTORE SHALL drive pc_load = 1 with pc_next = {ret_hi, stk_dout}, clear the highest-priority set in_service bit (INT0 first), and return to IDLE.
REQ-026 SP SHALL be an 8-bit internal register that wraps modulo 256 (8'hFF+1 = 8'h00, 8'h00-1 = 8'hFF) with no error flag.
REQ-027 irq_req and reti SHALL be ignored in every state except IDLE.
REQ-028 Outputs stk_we, stk_re, pc_load and int_ack SHALL be 0 in any state that does not drive them.

Reset
REQ-029 When rst_n = 0, asynchronously: state = IDLE, SP = 8'h07, in_service = 0, pc_ret = 0, ret_hi = 0, and all outputs = 0.
REQ-030 Reset mid-push or mid-pop SHALL abandon the sequence; no stack write or pc_load may occur in the cycle after deassertion.

Configuration
REQ-031 Macro ISR_NEST_EN SHALL enable two-level nesting.
REQ-032 With ISR_NEST_EN defined, INT0 SHALL also be eligible when in_service == 2'b01, preempting INT1. The stack then holds two frames, and the first RETI SHALL return to the INT1 handler with in_service = 2'b01.
REQ-033 Without ISR_NEST_EN, any set in_service bit SHALL block all requests.

Verification
REQ-034 Scenario: reset, then irq_req = 2'b10, pc_in = 16'h1234, instr_done -> stack[8] = 8'h34, stack[9] = 8'h12, pc_next = 16'h0003 at N+3, int_ack = 2'b10, in_service = 2'b10, SP = 8'h09.
REQ-035 Scenario: after REQ-034, reti -> stk_re at SP 8'h09 then 8'h08, pc_next = 16'h1234, in_service = 0, SP = 8'h07.
REQ-036 Scenario: irq_req = 2'b11 with instr_done -> INT0 serviced, pc_next = 16'h0003; irq_req = 2'b01 held with instr_done -> no second entry while in service.
REQ-037 Scenario: ISR_NEST_EN, INT1 in service at PC 16'h2000, INT0 request at pc_in = 16'h2100 -> in_service = 2'b11, SP = 8'h0B. Two RETIs return to 16'h2100 then 16'h2000. Without the macro, the INT0 request is held off.
REQ-038 Scenario: SP preset path via reset, then 124 nested pushes are not possible; instead force SP = 8'hFF by backdoor, take INT1 -> writes at 8'h00 and 8'h01, SP = 8'h01.
REQ-039 Scenario: rst_n low during PUSH_H -> state = IDLE, SP = 8'h07, no pc_load, in_service = 0.
